// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_pkg
// Brief    : Shared types and constants for the sequential binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_DISPLAY = 9999;

  typedef logic [3:0] bcd_digit_t;

  // ceil(width*log10(2) + 1) in fixed point (log10(2) ~ 0.30103)
  function automatic int scratch_digits(input int width);
    return (width * 30103 + 199999) / 100000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Brief    : Double-dabble correction cell: adds 3 to a BCD nibble that is >= 5.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t nib_in,
  output bcd_digit_t nib_out
);

  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential double-dabble converter, one bit per cycle, four BCD digits out.
//            Macro BIN2BCD_SATURATE_EN clamps values above 9999 to 9999.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       split_nr_0,
  output logic [3:0]       split_nr_1,
  output logic [3:0]       split_nr_2,
  output logic [3:0]       split_nr_3
);

  localparam int NDIG = scratch_digits(WIDTH);
  localparam int SW   = 4 * NDIG;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_DISPLAY);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic [SW-1:0]     scratch_adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_cap_q, ovf_cap_d;
  logic              overflow_q, overflow_d;
  logic [3:0][3:0]   digit_q, digit_d;

  for (genvar i = 0; i < NDIG; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (scratch_q[4*i +: 4]),
      .nib_out (scratch_adj[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_cap_d  = ovf_cap_q;
    overflow_d = overflow_q;
    digit_d    = digit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          ovf_cap_d = (bin_in > MAX_VAL);
        end
      end
      SHIFT: begin
        scratch_d = {scratch_adj[SW-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        // Result registers are written on the edge entering DONE so they are valid with done.
        if (cnt_q == CW'(1)) begin
          overflow_d = ovf_cap_q;
          for (int k = 0; k < 4; k++) digit_d[k] = scratch_d[4*k +: 4];
`ifdef BIN2BCD_SATURATE_EN
          if (ovf_cap_q) begin
            for (int k = 0; k < 4; k++) digit_d[k] = 4'd9;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_cap_q  <= 1'b0;
      overflow_q <= 1'b0;
      digit_q    <= '0;
    end else begin
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_cap_q  <= ovf_cap_d;
      overflow_q <= overflow_d;
      digit_q    <= digit_d;
    end
  end

  assign overflow   = overflow_q;
  assign split_nr_0 = digit_q[0];
  assign split_nr_1 = digit_q[1];
  assign split_nr_2 = digit_q[2];
  assign split_nr_3 = digit_q[3];

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Directed vector bench for bin2bcd_seq (WIDTH=14).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int WIDTH = 14;
`ifdef BIN2BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy, done, overflow;
  logic [3:0]       s0, s1, s2, s3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .split_nr_0 (s0),
    .split_nr_1 (s1),
    .split_nr_2 (s2),
    .split_nr_3 (s3)
  );

  typedef struct {
    logic [WIDTH-1:0] bin;
    logic [15:0]      bcd;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] digits();
    return {s3, s2, s1, s0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One conversion: checks hold-before-done, latency (edges counted including the accept edge),
  // result at the done cycle, and that done is a single-cycle pulse.
  task automatic run_conv(input logic [WIDTH-1:0] v, input logic [15:0] exp_d, input logic exp_o,
                          input logic [15:0] prev_d, input logic prev_o, input string tag);
    int  edges;
    bit  seen;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = ~v;
    edges  = 1;
    seen   = 1'b0;
    while (!seen && edges < 4 * WIDTH) begin
      if (edges == 4) begin
        check({tag, " busy mid"}, 32'(busy), 32'd1);
        check({tag, " hold digits"}, 32'(digits()), 32'(prev_d));
        check({tag, " hold ovf"}, 32'(overflow), 32'(prev_o));
      end
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(edges), 32'(WIDTH + 1));
    check({tag, " digits"}, 32'(digits()), 32'(exp_d));
    check({tag, " ovf"}, 32'(overflow), 32'(exp_o));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] prev_d;
    logic        prev_o;
    int          dones;
    int          t_prev;
    int          n;
    int          k;
    logic [15:0] got;

    vecs[0] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
    vecs[1] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
    vecs[2] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
    vecs[3] = '{bin: 14'd12345, bcd: SAT ? 16'h9999 : 16'h2345, ovf: 1'b1};
    vecs[4] = '{bin: 14'd5,     bcd: 16'h0005, ovf: 1'b0};
    vecs[5] = '{bin: 14'd10000, bcd: SAT ? 16'h9999 : 16'h0000, ovf: 1'b1};
    vecs[6] = '{bin: 14'd8080,  bcd: 16'h8080, ovf: 1'b0};
    vecs[7] = '{bin: 14'd16383, bcd: SAT ? 16'h9999 : 16'h6383, ovf: 1'b1};

    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ovf", 32'(overflow), 32'd0);
    check("reset digits", 32'(digits()), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    prev_d = 16'h0000;
    prev_o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, prev_d, prev_o, $sformatf("vec%0d", i));
      prev_d = vecs[i].bcd;
      prev_o = vecs[i].ovf;
    end

    // Starts while busy are dropped; bin_in churn after capture is ignored.
    dones = 0;
    got   = '0;
    @(negedge clk); start = 1'b1; bin_in = 14'd4321;
    @(negedge clk); start = 1'b0; bin_in = 14'd1111;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; bin_in = 14'd2222;
    @(negedge clk); start = 1'b1; bin_in = 14'd3333;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        got = digits();
      end
    end
    check("busy-start dones", 32'(dones), 32'd1);
    check("busy-start digits", 32'(got), 32'h4321);
    check("busy-start idle", 32'(busy), 32'd0);

    // Reset mid-conversion aborts and clears outputs.
    @(negedge clk); start = 1'b1; bin_in = 14'd5678;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort digits", 32'(digits()), 32'd0);
    check("abort ovf", 32'(overflow), 32'd0);
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (j == 2) begin
        @(negedge clk);
        reset = 1'b1;
      end
    end
    check("abort no done", 32'(dones), 32'd0);
    check("abort digits after", 32'(digits()), 32'd0);
    run_conv(14'd42, 16'h0042, 1'b0, 16'h0000, 1'b0, "post-reset");

    // Start held high: back-to-back conversions with one idle cycle.
    @(negedge clk); start = 1'b1; bin_in = 14'd777;
    t_prev = -1;
    n      = 0;
    k      = 0;
    while (n < 4 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (done) begin
        if (t_prev >= 0) check("b2b period", 32'(k - t_prev), 32'(WIDTH + 2));
        check("b2b digits", 32'(digits()), 32'h0777);
        t_prev = k;
        n++;
      end
    end
    check("b2b pulses", 32'(n), 32'd4);
    @(negedge clk); start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
